sap_datapath: RTL and testbench

SAP_DATAPATH -- requirements
Module: sap_datapath

---
 rtl/sap_datapath.sv | 149 ++++++++++++++
 tb/tb_sap_datapath.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_datapath.sv
// sap_datapath
//   Datapath of a SAP-style 8-bit computer: program counter, memory address
//   register, 16x8 RAM, instruction register, accumulator A, register B,
//   output register, ALU with zero/carry flags and a single shared 8-bit bus.
//   The control unit drives ControlSignal every cycle and reads back the
//   opcode and flags.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-low reset (RAM contents are kept)
//   ControlSignal 16-bit control word (bit map below)
//   prog_we       program-load write strobe into RAM
//   prog_addr     program-load RAM address
//   prog_data     program-load RAM data
//   opcode        IR[7:4]
//   flagReg       {Z, C}
//   out_data      output register
//   bus_dbg       current bus value (combinational)
//   bus_err       sticky: more than one bus driver enabled at a clock edge
//
// ControlSignal bits
//   0 Cp  1 Ep  2 Lp  3 Lm  4 Er  5 Wr  6 Li  7 Ei
//   8 La  9 Ea 10 Su 11 Eu 12 Lb 13 Lo 14 Lf 15 Ca
module sap_datapath #(
    parameter logic [7:0] BUS_IDLE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ControlSignal,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [3:0]  opcode,
    output logic [1:0]  flagReg,
    output logic [7:0]  out_data,
    output logic [7:0]  bus_dbg,
    output logic        bus_err
);

    logic cp, ep, lp, lm, er, wr, li, ei, la, ea, su, eu, lb, lo, lf, ca;

    assign cp = ControlSignal[0];
    assign ep = ControlSignal[1];
    assign lp = ControlSignal[2];
    assign lm = ControlSignal[3];
    assign er = ControlSignal[4];
    assign wr = ControlSignal[5];
    assign li = ControlSignal[6];
    assign ei = ControlSignal[7];
    assign la = ControlSignal[8];
    assign ea = ControlSignal[9];
    assign su = ControlSignal[10];
    assign eu = ControlSignal[11];
    assign lb = ControlSignal[12];
    assign lo = ControlSignal[13];
    assign lf = ControlSignal[14];
    assign ca = ControlSignal[15];

    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] out_reg;
    logic [1:0] flags;
    logic       err;
    logic [7:0] mem [16];

    logic [7:0] bus;
    logic [8:0] alu_res;
    logic [8:0] step_res;
    logic [4:0] drv_en;
    logic       multi_drv;

    // 9-bit add/subtract; subtraction is A + ~B + 1, so carry=1 means no borrow.
    function automatic logic [8:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic sub);
        logic [7:0] bo;
        bo = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bo} + {8'h00, sub};
    endfunction

    // Accumulator step: +1, or -1 computed as A + 8'hFF so the carry out
    // is the no-borrow indication, consistent with the ALU subtract.
    function automatic logic [8:0] step_calc(input logic [7:0] a, input logic dec);
        return {1'b0, a} + (dec ? 9'h0FF : 9'h001);
    endfunction

    assign alu_res  = alu_calc(a_reg, b_reg, su);
    assign step_res = step_calc(a_reg, su);

    always_comb begin
        bus = BUS_IDLE;
        if (eu)      bus = alu_res[7:0];
        else if (ea) bus = a_reg;
        else if (er) bus = mem[mar];
        else if (ei) bus = {4'h0, ir[3:0]};
        else if (ep) bus = {4'h0, pc};
    end

    // Two or more drivers enabled: clear the lowest set bit and see if any remain.
    assign drv_en    = {eu, ea, er, ei, ep};
    assign multi_drv = |(drv_en & (drv_en - 5'd1));

    // RAM lives in the reset block only so that a write presented while reset
    // is asserted is dropped; the array itself is never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= 4'h0;
            mar     <= 4'h0;
            ir      <= 8'h00;
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            out_reg <= 8'h00;
            flags   <= 2'b00;
            err     <= 1'b0;
        end else begin
            if (lp)      pc <= bus[3:0];
            else if (cp) pc <= pc + 4'h1;

            if (lm) mar <= bus[3:0];
            if (li) ir <= bus;
            if (lb) b_reg <= bus;
            if (lo) out_reg <= bus;

            if (la)      a_reg <= bus;
            else if (ca) a_reg <= step_res[7:0];

            // Step flags only when the step actually updates A; a load from
            // the bus keeps ALU-derived flags.
            if (lf) begin
                if (ca && !la) flags <= {step_res[7:0] == 8'h00, step_res[8]};
                else           flags <= {alu_res[7:0] == 8'h00, alu_res[8]};
            end

            if (multi_drv) err <= 1'b1;

            if (prog_we)  mem[prog_addr] <= prog_data;
            else if (wr)  mem[mar]       <= bus;
        end
    end

    assign opcode   = ir[7:4];
    assign flagReg  = flags;
    assign out_data = out_reg;
    assign bus_dbg  = bus;
    assign bus_err  = err;

endmodule

// File: tb/tb_sap_datapath.sv
module tb_sap_datapath;

    localparam logic [15:0] CP = 16'h0001;
    localparam logic [15:0] EP = 16'h0002;
    localparam logic [15:0] LP = 16'h0004;
    localparam logic [15:0] LM = 16'h0008;
    localparam logic [15:0] ER = 16'h0010;
    localparam logic [15:0] WR = 16'h0020;
    localparam logic [15:0] LI = 16'h0040;
    localparam logic [15:0] EI = 16'h0080;
    localparam logic [15:0] LA = 16'h0100;
    localparam logic [15:0] EA = 16'h0200;
    localparam logic [15:0] SU = 16'h0400;
    localparam logic [15:0] EU = 16'h0800;
    localparam logic [15:0] LB = 16'h1000;
    localparam logic [15:0] LO = 16'h2000;
    localparam logic [15:0] LF = 16'h4000;
    localparam logic [15:0] CA = 16'h8000;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ControlSignal;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [1:0]  flagReg;
    logic [7:0]  out_data;
    logic [7:0]  bus_dbg;
    logic        bus_err;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] got;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] mar_t;

    sap_datapath #(.BUS_IDLE(8'h00)) dut (
        .clk(clk), .rst(rst), .ControlSignal(ControlSignal),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .flagReg(flagReg), .out_data(out_data),
        .bus_dbg(bus_dbg), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Stimulus helpers; all start and end 1ns after a rising edge.
    task automatic tick(input logic [15:0] cw);
        ControlSignal = cw;
        @(posedge clk);
        #1;
        ControlSignal = 16'h0000;
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic peek(input logic [15:0] cw, output logic [7:0] v);
        ControlSignal = cw;
        #1;
        v = bus_dbg;
        ControlSignal = 16'h0000;
    endtask

    // Load a register from a byte staged in RAM at the current MAR.
    task automatic load_via_ram(input logic [7:0] v, input logic [15:0] ld);
        prog(mar_t, v);
        tick(ER | ld);
    endtask

    task automatic pop_cmp(input logic [7:0] actual);
        e = sb.pop_front();
        n_checks++;
        if (actual !== e.val) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", e.name, actual, e.val);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ControlSignal = 16'h0000;
        prog_we = 1'b0;
        prog_addr = 4'h0;
        prog_data = 8'h00;
        #3;
        sb.push_back('{"rst_opcode", 8'h00});
        sb.push_back('{"rst_flags", 8'h00});
        sb.push_back('{"rst_out", 8'h00});
        sb.push_back('{"rst_bus_err", 8'h00});
        sb.push_back('{"rst_bus_idle", 8'h00});
        pop_cmp({4'h0, opcode});
        pop_cmp({6'h0, flagReg});
        pop_cmp(out_data);
        pop_cmp({7'h0, bus_err});
        pop_cmp(bus_dbg);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mar_t = 4'h0;
        sb.push_back('{"rst_pc", 8'h00});
        peek(EP, got);
        pop_cmp(got);
    endtask

    task automatic test_fetch_lda;
        prog(4'h0, 8'h09);
        prog(4'h9, 8'h2A);
        tick(EP | LM);
        tick(ER | LI | CP);
        tick(EI | LM);
        mar_t = 4'h9;
        tick(ER | LA);
        sb.push_back('{"lda_opcode", 8'h00});
        sb.push_back('{"lda_a", 8'h2A});
        sb.push_back('{"lda_pc", 8'h01});
        pop_cmp({4'h0, opcode});
        peek(EA, got);
        pop_cmp(got);
        peek(EP, got);
        pop_cmp(got);
    endtask

    task automatic test_alu;
        load_via_ram(8'h80, LA);
        load_via_ram(8'h80, LB);
        tick(EU | LA | LF);
        sb.push_back('{"add_a", 8'h00});
        sb.push_back('{"add_flags", 8'h03});
        peek(EA, got);
        pop_cmp(got);
        pop_cmp({6'h0, flagReg});
        load_via_ram(8'h07, LB);
        load_via_ram(8'h05, LA);
        tick(EU | SU | LA | LF);
        sb.push_back('{"sub_a", 8'hFE});
        sb.push_back('{"sub_flags", 8'h00});
        peek(EA, got);
        pop_cmp(got);
        pop_cmp({6'h0, flagReg});
        // FE + 07 = 0x105 on the ALU output
        sb.push_back('{"alu_bus_add", 8'h05});
        peek(EU, got);
        pop_cmp(got);
        tick(EA | LO);
        sb.push_back('{"out_reg", 8'hFE});
        pop_cmp(out_data);
    endtask

    task automatic test_step;
        load_via_ram(8'hFF, LA);
        tick(CA | LF);
        sb.push_back('{"inc_a", 8'h00});
        sb.push_back('{"inc_flags", 8'h03});
        peek(EA, got);
        pop_cmp(got);
        pop_cmp({6'h0, flagReg});
        tick(CA | SU | LF);
        sb.push_back('{"dec_a", 8'hFF});
        sb.push_back('{"dec_flags", 8'h00});
        peek(EA, got);
        pop_cmp(got);
        pop_cmp({6'h0, flagReg});
        // B=07, A=FF: La beats Ca, flags from ALU (0x106 -> Z=0, C=1)
        tick(EU | LA | CA | LF);
        sb.push_back('{"la_over_ca_a", 8'h06});
        sb.push_back('{"la_over_ca_flags", 8'h01});
        peek(EA, got);
        pop_cmp(got);
        pop_cmp({6'h0, flagReg});
    endtask

    task automatic test_pc;
        load_via_ram(8'h0F, LA);
        tick(EA | LP);
        sb.push_back('{"pc_load_f", 8'h0F});
        peek(EP, got);
        pop_cmp(got);
        tick(CP);
        sb.push_back('{"pc_wrap", 8'h00});
        peek(EP, got);
        pop_cmp(got);
        load_via_ram(8'h37, LA);
        tick(EA | LP | CP);
        sb.push_back('{"pc_lp_over_cp", 8'h07});
        peek(EP, got);
        pop_cmp(got);
    endtask

    task automatic test_ram_write;
        tick(CA);                // A = 38
        tick(EA | WR);
        sb.push_back('{"ram_wr", 8'h38});
        peek(ER, got);
        pop_cmp(got);
        prog_we   = 1'b1;
        prog_addr = mar_t;
        prog_data = 8'hC3;
        tick(EA | WR);
        prog_we = 1'b0;
        sb.push_back('{"prog_we_wins", 8'hC3});
        peek(ER, got);
        pop_cmp(got);
    endtask

    task automatic test_bus_err;
        load_via_ram(8'h11, LA);
        ControlSignal = EA | ER;
        #1;
        sb.push_back('{"contend_bus", 8'h11});
        sb.push_back('{"err_before_edge", 8'h00});
        pop_cmp(bus_dbg);
        pop_cmp({7'h0, bus_err});
        @(posedge clk);
        #1;
        ControlSignal = 16'h0000;
        tick(16'h0000);
        tick(16'h0000);
        sb.push_back('{"err_sticky", 8'h01});
        pop_cmp({7'h0, bus_err});
    endtask

    task automatic test_reset_mid;
        prog(4'h3, 8'h77);
        load_via_ram(8'h55, LA);
        tick(EA | LO | LF);
        #2;
        rst = 1'b0;
        ControlSignal = EA | WR;
        #1;
        sb.push_back('{"mid_rst_out", 8'h00});
        sb.push_back('{"mid_rst_flags", 8'h00});
        sb.push_back('{"mid_rst_err", 8'h00});
        sb.push_back('{"mid_rst_opcode", 8'h00});
        sb.push_back('{"mid_rst_a", 8'h00});
        pop_cmp(out_data);
        pop_cmp({6'h0, flagReg});
        pop_cmp({7'h0, bus_err});
        pop_cmp({4'h0, opcode});
        pop_cmp(bus_dbg);        // Ea drives the cleared A
        @(posedge clk);          // edge inside reset: write must be dropped
        #1;
        ControlSignal = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mar_t = 4'h0;
        sb.push_back('{"ram0_kept", 8'h09});
        peek(ER, got);
        pop_cmp(got);
        prog(4'h0, 8'h03);
        tick(ER | LM);
        mar_t = 4'h3;
        sb.push_back('{"ram3_kept", 8'h77});
        peek(ER, got);
        pop_cmp(got);
    endtask

    initial begin
        test_reset();
        test_fetch_lda();
        test_alu();
        test_step();
        test_pc();
        test_ram_write();
        test_bus_err();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
